fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 103 ++++++++++
 tb/tb_fifo_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised single-clock FIFO with edge/level request modes
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2,
  parameter int EDGE_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              wr_q;
  logic              rd_q;
  logic              wr_req;
  logic              rd_req;
  logic              wr_acc;
  logic              rd_acc;

  // Edge mode turns a held request into a single operation.
  assign wr_req = (EDGE_MODE != 0) ? (wr & ~wr_q) : wr;
  assign rd_req = (EDGE_MODE != 0) ? (rd & ~rd_q) : rd;

  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign data_out     = mem[rptr[ADDR_W-1:0]];

  assign wr_acc = wr_req & ~full & ~clr;
  assign rd_acc = rd_req & ~empty & ~clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr;
      rd_q <= rd;
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is never reset; contents survive clr and reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDR_W-1:0]] <= data_in;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_req && full)  ovf_q <= 1'b1;
      if (rd_req && empty) udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - scoreboard bench for fifo_param against a queue model
// Expected error flags follow FIFO_ERR_FLAGS_EN.
module tb_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] data_out, data_out0;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic       full0, empty0, almost_full0, almost_empty0, overflow0, underflow0;
  logic [4:0] count, count0;

  fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .EDGE_MODE(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out0), .full(full0), .empty(empty0), .almost_full(almost_full0),
    .almost_empty(almost_empty0), .count(count0), .overflow(overflow0), .underflow(underflow0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  logic rd_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every read edge the DUT can serve must return the oldest expected word.
  always @(negedge clk) begin
    if (reset && !clr && rd && !rd_prev && !empty) begin
      if (exp_q.size() == 0) check("read_unexpected", 1, 0);
      else begin
        check("data_out", int'(data_out), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    rd_prev = (!reset || clr) ? 1'b0 : rd;
  end

  task automatic check_status(input string tag);
    int n;
    n = model_q.size();
    check({tag, " count"}, int'(count), n);
    check({tag, " full"}, int'(full), int'(n == DEPTH));
    check({tag, " empty"}, int'(empty), int'(n == 0));
    check({tag, " almost_full"}, int'(almost_full), int'(n >= AF));
    check({tag, " almost_empty"}, int'(almost_empty), int'(n <= AE));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, " overflow"}, int'(overflow), int'(m_ovf));
    check({tag, " underflow"}, int'(underflow), int'(m_udf));
`else
    check({tag, " overflow"}, int'(overflow), 0);
    check({tag, " underflow"}, int'(underflow), 0);
`endif
  endtask

  // One request pulse followed by an idle cycle; model decides acceptance from occupancy.
  task automatic op(input bit w, input bit r, input logic [7:0] d);
    bit was_full;
    bit was_empty;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (r && !was_empty) exp_q.push_back(model_q.pop_front());
    if (w && !was_full) model_q.push_back(d);
    if (w && was_full) m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    wr = w; rd = r; data_in = d;
    @(posedge clk); #2;
    wr = 1'b0; rd = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    model_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    model_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_status("reset");
    check("reset count0", int'(count0), 0);
    reset = 1'b1;
    @(posedge clk); #2;

    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 8'(i));
      check_status("fill");
    end
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check_status("drain");
    end

    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'($urandom));
    op(1'b1, 1'b1, 8'hEE);
    check_status("full_wr_rd");
    for (int i = 0; i < 15; i++) op(1'b0, 1'b1, 8'h00);
    check_status("after_full_drain");

    op(1'b1, 1'b1, 8'h3C);
    check_status("empty_wr_rd");
    check("empty_wr_rd data_out", int'(data_out), 8'h3C);
    op(1'b0, 1'b1, 8'h00);
    do_clr();
    check_status("clr");

    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'($urandom));
    check_status("wrap");
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 8'h00);
    check_status("wrap_drain");

    do_reset();
    wr = 1'b1; data_in = 8'hA5;
    repeat (5) @(posedge clk);
    #2;
    wr = 1'b0;
    model_q.push_back(8'hA5);
    @(posedge clk); #2;
    check("hold edge_mode count", int'(count), 1);
    check("hold level_mode count0", int'(count0), 5);
    op(1'b0, 1'b1, 8'h00);
    check_status("hold_read");

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_clr();
      else if (i < 150) op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 8'($urandom));
      else op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      check_status("random");
    end
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00);
    check_status("random_drain");

    do_clr();
    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 8'(8'h50 + i));
    check_status("seven");
    #1;
    reset = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    check("async_reset count", int'(count), 0);
    check("async_reset empty", int'(empty), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    clr = 1'b1; wr = 1'b1; data_in = 8'h77;
    @(posedge clk); #2;
    clr = 1'b0; wr = 1'b0;
    @(posedge clk); #2;
    check_status("clr_with_wr");
    op(1'b1, 1'b0, 8'h42);
    op(1'b0, 1'b1, 8'h00);
    check_status("post_reset");

    check("pending_reads", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
